// File: rtl/lane_ser_pkg.sv
// Shared types for the lane serializer: lane indices, serializer states and
// the default-width triplet carried from the three-lane array stage.
package lane_ser_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        LANE_A = 2'd0,
        LANE_B = 2'd1,
        LANE_C = 2'd2
    } lane_idx_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_A,
        S_B,
        S_C
    } ser_state_t;

    typedef struct packed {
        logic [DEFAULT_WIDTH-1:0] a;
        logic [DEFAULT_WIDTH-1:0] b;
        logic [DEFAULT_WIDTH-1:0] c;
    } triplet_t;

endpackage

// File: rtl/lane_serializer_triplet_fifo.sv
// Synchronous FIFO of triplets with wrap-bit pointers; only the pointers reset,
// the storage array does not.
module triplet_fifo
    import lane_ser_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = triplet_t
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    output entry_t                 head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    entry_t      mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    // Full is tested before any same-cycle pop, so a full FIFO never accepts a write.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign count   = wr_ptr - rd_ptr;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/lane_serializer.sv
// Buffers a/b/c lane triplets and replays each one as three beats on a single
// valid/ready stream for a one-lane sink.
module lane_serializer
    import lane_ser_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [WIDTH-1:0]       i_a,
    input  logic [WIDTH-1:0]       i_b,
    input  logic [WIDTH-1:0]       i_c,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [WIDTH-1:0]       o_data,
    output logic [1:0]             o_lane,
    output logic                   o_last,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] c;
    } lane_triplet_t;

    ser_state_t    state;
    ser_state_t    next_state;
    lane_triplet_t head;
    lane_triplet_t push_data;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          push_fire;
    logic          pop;

    assign push_data = '{a: i_a, b: i_b, c: i_c};
    assign push_fire = i_valid && !full;
    assign pop       = (state == S_C) && i_ready;
    assign o_ready   = !full;
    assign o_count   = count;

    triplet_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (lane_triplet_t)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .push      (i_valid),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= next_state;
    end

    // A same-cycle push into a one-entry FIFO still counts as a remaining entry, so no bubble.
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:  if (!empty)  next_state = S_A;
            S_A:     if (i_ready) next_state = S_B;
            S_B:     if (i_ready) next_state = S_C;
            S_C:     if (i_ready) next_state = ((count != CW'(1)) || push_fire) ? S_A : S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        o_valid = 1'b0;
        o_data  = '0;
        o_lane  = LANE_A;
        o_last  = 1'b0;
        unique case (state)
            S_A: begin
                o_valid = 1'b1;
                o_data  = head.a;
                o_lane  = LANE_A;
            end
            S_B: begin
                o_valid = 1'b1;
                o_data  = head.b;
                o_lane  = LANE_B;
            end
            S_C: begin
                o_valid = 1'b1;
                o_data  = head.c;
                o_lane  = LANE_C;
                o_last  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lane_serializer.sv
// Scoreboard bench for lane_serializer: accepted triplets queue their three expected
// beats, and a monitor pops and compares every beat the sink accepts.
`timescale 1ns/1ps
module tb_lane_serializer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [1:0]       lane;
        logic             last;
    } beat_t;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic             i_valid;
    logic             i_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic [WIDTH-1:0] i_c;
    logic             o_ready;
    logic             o_valid;
    logic [WIDTH-1:0] o_data;
    logic [1:0]       o_lane;
    logic             o_last;
    logic [CW-1:0]    o_count;

    beat_t            sb[$];
    int               checks   = 0;
    int               passes   = 0;
    int               full_obs = 0;
    int               bubbles;
    logic             clr;
    logic [1:0]       beat_idx;
    logic [WIDTH-1:0] tv [3];
    int               n;

    lane_serializer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_c     (i_c),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_lane  (o_lane),
        .o_last  (o_last),
        .o_count (o_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    // Offers one triplet and holds it until accepted; returns just after the accepting edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [WIDTH-1:0] c);
        int waited = 0;
        i_a     = a;
        i_b     = b;
        i_c     = c;
        i_valid = 1'b1;
        @(negedge i_clk);
        while (!o_ready && waited < 100) begin
            @(negedge i_clk);
            waited++;
        end
        if (!o_ready) checkOutput("push_timeout", 32'(o_ready), 32'd1);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int cyc = 0;
        @(negedge i_clk);
        #1;
        while ((sb.size() != 0 || o_valid) && cyc < 200) begin
            @(negedge i_clk);
            #1;
            cyc++;
        end
        checkOutput({name, "_drained"}, 32'(sb.size()), 32'd0);
        checkOutput({name, "_count"}, 32'(o_count), 32'd0);
        checkOutput({name, "_ready"}, 32'(o_ready), 32'd1);
        @(posedge i_clk);
        #1;
    endtask

    initial begin : monitor
        beat_t e;
        forever begin
            @(negedge i_clk);
            if (!i_rst && !o_ready) full_obs++;
            if (!i_rst && i_valid && o_ready) begin
                sb.push_back({i_a, 2'd0, 1'b0});
                sb.push_back({i_b, 2'd1, 1'b0});
                sb.push_back({i_c, 2'd2, 1'b1});
            end
            if (!i_rst && o_valid && i_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL unexpected_beat: got data %0h lane %0d, expected no beat",
                             o_data, o_lane);
                end else begin
                    e = sb.pop_front();
                    checkOutput("beat_data", 32'(o_data), 32'(e.data));
                    checkOutput("beat_lane", 32'(o_lane), 32'(e.lane));
                    checkOutput("beat_last", 32'(o_last), 32'(e.last));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 200us");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_a     = '0;
        i_b     = '0;
        i_c     = '0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        @(negedge i_clk);
        checkOutput("rst_valid", 32'(o_valid), 32'd0);
        checkOutput("rst_data",  32'(o_data),  32'd0);
        checkOutput("rst_lane",  32'(o_lane),  32'd0);
        checkOutput("rst_last",  32'(o_last),  32'd0);
        checkOutput("rst_count", 32'(o_count), 32'd0);
        checkOutput("rst_ready", 32'(o_ready), 32'd1);
        @(posedge i_clk);
        #1;

        $display("[TB] single triplet and latency");
        i_ready = 1'b1;
        applyStimulus(8'hFF, 8'h00, 8'hFF);
        @(negedge i_clk);
        checkOutput("lat_idle_valid", 32'(o_valid), 32'd0);
        checkOutput("lat_idle_count", 32'(o_count), 32'd1);
        @(negedge i_clk);
        checkOutput("lat_first_valid", 32'(o_valid), 32'd1);
        checkOutput("lat_first_lane",  32'(o_lane),  32'd0);
        waitDrain("single");

        $display("[TB] fill to full then release");
        i_ready = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(8'(i), 8'(i + 16), 8'(i + 32));
        @(negedge i_clk);
        checkOutput("fill_ready", 32'(o_ready), 32'd0);
        checkOutput("fill_count", 32'(o_count), 32'd4);
        @(posedge i_clk);
        #1;
        i_a     = 8'd4;
        i_b     = 8'd20;
        i_c     = 8'd36;
        i_valid = 1'b1;
        repeat (2) @(negedge i_clk);
        checkOutput("holdoff_ready", 32'(o_ready), 32'd0);
        checkOutput("holdoff_count", 32'(o_count), 32'd4);
        @(posedge i_clk);
        #1;
        i_ready = 1'b1;
        bubbles = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge i_clk);
            if (!o_valid) bubbles++;
            clr = i_valid && o_ready;
            @(posedge i_clk);
            #1;
            if (clr) i_valid = 1'b0;
        end
        checkOutput("no_bubble", 32'(bubbles), 32'd0);
        checkOutput("fifth_accepted", 32'(i_valid), 32'd0);
        i_valid = 1'b0;
        waitDrain("burst");

        $display("[TB] ready toggling mid-triplet");
        tv[0]   = 8'h11;
        tv[1]   = 8'h22;
        tv[2]   = 8'h33;
        i_ready = 1'b0;
        applyStimulus(tv[0], tv[1], tv[2]);
        @(negedge i_clk);
        @(posedge i_clk);
        #1;
        beat_idx = 2'd0;
        for (int k = 0; k < 6; k++) begin
            i_ready = k[0];
            @(negedge i_clk);
            checkOutput("toggle_valid", 32'(o_valid), 32'd1);
            checkOutput("toggle_lane",  32'(o_lane),  32'(beat_idx));
            checkOutput("toggle_data",  32'(o_data),  32'(tv[beat_idx]));
            if (i_ready) beat_idx = beat_idx + 2'd1;
            @(posedge i_clk);
            #1;
        end
        i_ready = 1'b1;
        waitDrain("toggle");

        $display("[TB] push against full during lane-c pop");
        i_ready = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(8'(64 + i), 8'(80 + i), 8'(96 + i));
        i_a     = 8'hA0;
        i_b     = 8'hA1;
        i_c     = 8'hA2;
        i_valid = 1'b1;
        i_ready = 1'b1;
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (!(o_valid && o_lane == 2'd2) && n < 50);
        checkOutput("pre_pop_count", 32'(o_count), 32'd4);
        checkOutput("pre_pop_ready", 32'(o_ready), 32'd0);
        @(negedge i_clk);
        checkOutput("pop_only_count",  32'(o_count), 32'd3);
        checkOutput("ready_after_pop", 32'(o_ready), 32'd1);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        waitDrain("fullpop");

        $display("[TB] reset while serializing");
        i_ready = 1'b0;
        applyStimulus(8'h01, 8'h02, 8'h03);
        applyStimulus(8'h04, 8'h05, 8'h06);
        i_ready = 1'b1;
        @(negedge i_clk);
        @(posedge i_clk);
        #1;
        i_ready = 1'b0;
        @(negedge i_clk);
        checkOutput("pre_rst_lane",  32'(o_lane),  32'd1);
        checkOutput("pre_rst_count", 32'(o_count), 32'd2);
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        sb.delete();
        @(negedge i_clk);
        checkOutput("post_rst_valid", 32'(o_valid), 32'd0);
        checkOutput("post_rst_count", 32'(o_count), 32'd0);
        checkOutput("post_rst_ready", 32'(o_ready), 32'd1);
        @(posedge i_clk);
        #1;
        i_ready = 1'b1;
        applyStimulus(8'h5A, 8'hA5, 8'h3C);
        waitDrain("post_rst");

        $display("[TB] pointer wrap");
        i_ready  = 1'b1;
        full_obs = 0;
        for (int i = 0; i < 2 * DEPTH + 1; i++) applyStimulus(8'(128 + i), 8'(160 + i), 8'(192 + i));
        checkOutput("wrap_full_seen", 32'(full_obs != 0), 32'd1);
        waitDrain("wrap");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
